// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler
//   Time-multiplexed FIR controller. Accepts one sample per in_valid/in_ready
//   handshake into a NUM_TAPS-deep delay line (x[0] newest), runs NUM_TAPS
//   multiply-accumulate steps through a single multiplier/adder, then offers
//   the result on an out_valid/out_ready port.
//
//   States:
//     IDLE | waiting for a sample; in_ready=1, clear flushes the delay line
//     MAC  | one product per cycle, tap index k = 0 .. NUM_TAPS-1
//     OUT  | result held on out_data until out_ready
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   coeffs        flattened coefficients, h[k] = coeffs[k*H_WORD_LEN +: H_WORD_LEN]
//   clear         delay-line flush, only honoured in IDLE without in_valid
//   in_data/in_valid/in_ready     sample input handshake
//   out_data/out_valid/out_ready  filtered sample output handshake
//   busy          high while in MAC or OUT
module fir_mac_scheduler #(
  parameter int NUM_TAPS   = 4,
  parameter int X_WORD_LEN = 9,
  parameter int X_FRAC_LEN = 8,
  parameter int H_WORD_LEN = 9,
  parameter int H_FRAC_LEN = 8,
  parameter int Y_WORD_LEN = 10,
  parameter int Y_FRAC_LEN = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_TAPS*H_WORD_LEN-1:0]   coeffs,
  input  logic                             clear,
  input  logic [X_WORD_LEN-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [Y_WORD_LEN-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam int P_W    = X_WORD_LEN + H_WORD_LEN;
  localparam int P_FRAC = X_FRAC_LEN + H_FRAC_LEN;
  localparam int K_W    = $clog2(NUM_TAPS);
  localparam int ACC_W  = P_W + K_W;
  localparam int SL_LO  = P_FRAC - Y_FRAC_LEN;
  localparam int SL_HI  = SL_LO + Y_WORD_LEN - 1;
  // Widen the accumulator by sign extension when the output slice reaches
  // above its top bit.
  localparam int EXT_W  = (SL_HI + 1 > ACC_W) ? SL_HI + 1 : ACC_W;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state;
  logic signed [X_WORD_LEN-1:0]  xd [NUM_TAPS];
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       acc_next;
  logic [K_W-1:0]                k;
  logic signed [X_WORD_LEN-1:0]  x_k;
  logic signed [H_WORD_LEN-1:0]  h_k;
  logic signed [P_W-1:0]         prod;

  // Truncate toward -inf (drop LSBs) and wrap (drop MSBs).
  function automatic logic [Y_WORD_LEN-1:0] to_y(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(a);
    return e[SL_HI:SL_LO];
  endfunction

  always_comb begin
    x_k      = xd[k];
    h_k      = coeffs[int'(k)*H_WORD_LEN +: H_WORD_LEN];
    prod     = P_W'(x_k) * P_W'(h_k);
    acc_next = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < NUM_TAPS; i++) xd[i] <= '0;
      acc       <= '0;
      k         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) xd[i] <= xd[i-1];
            xd[0]    <= in_data;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MAC;
          end else if (clear) begin
            for (int i = 0; i < NUM_TAPS; i++) xd[i] <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == K_W'(NUM_TAPS - 1)) begin
            // Output register takes the sum including the last product.
            out_data  <= to_y(acc_next);
            out_valid <= 1'b1;
            k         <= '0;
            state     <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Testbench for fir_mac_scheduler: a transaction-level model (convolution of
// the sample history plus a countdown to the output) is checked against the
// DUT every cycle, and directed scenarios pin literal results.
module tb_fir_mac_scheduler;
  localparam int N   = 4;
  localparam int XW  = 9;
  localparam int HW  = 9;
  localparam int YW  = 10;
  localparam int SHR = 8 + 8 - 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*HW-1:0]   coeffs;
  logic              clear = 1'b0;
  logic [XW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [YW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;

  int total = 0;
  int bad   = 0;

  fir_mac_scheduler #(
    .NUM_TAPS(N), .X_WORD_LEN(XW), .X_FRAC_LEN(8), .H_WORD_LEN(HW),
    .H_FRAC_LEN(8), .Y_WORD_LEN(YW), .Y_FRAC_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .coeffs(coeffs), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [N*HW-1:0] H_IMP  = {9'h0C0, 9'h020, 9'h180, 9'h040};
  localparam logic [N*HW-1:0] H_NEG1 = {9'h100, 9'h100, 9'h100, 9'h100};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              hist [N];
  bit              m_idle = 1'b1;
  bit              m_outv = 1'b0;
  logic [YW-1:0]   m_outd = '0;
  logic [YW-1:0]   m_pend = '0;
  int              m_cnt = 0;
  int              cyc = 0;
  int              n_acc = 0;
  int              n_out = 0;
  int              acc_cyc[$];
  int              out_cyc[$];
  int              rise_cyc[$];
  logic [YW-1:0]   out_q[$];

  initial for (int i = 0; i < N; i++) hist[i] = 0;

  // y = sum h[k]*x[n-k], floored to the output LSB, wrapped to YW bits.
  function automatic logic [YW-1:0] conv();
    longint s = 0;
    logic signed [HW-1:0] h;
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      h = coeffs[i*HW +: HW];
      s += longint'(h) * longint'(hist[i]);
    end
    s = s >>> SHR;
    r = s;
    return r[YW-1:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) hist[i] = 0;
      m_idle = 1'b1;
      m_outv = 1'b0;
      m_outd = '0;
      m_cnt  = 0;
    end else begin
      cyc++;
      if (m_idle) begin
        if (in_valid) begin
          for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = int'($signed(in_data));
          m_pend  = conv();
          m_idle  = 1'b0;
          m_cnt   = N;
          n_acc++;
          acc_cyc.push_back(cyc);
        end else if (clear) begin
          for (int i = 0; i < N; i++) hist[i] = 0;
        end
      end else if (m_outv) begin
        if (out_ready) begin
          out_q.push_back(out_data);
          out_cyc.push_back(cyc);
          n_out++;
          m_outv = 1'b0;
          m_idle = 1'b1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_outv = 1'b1;
          m_outd = m_pend;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_idle));
    chk("busy", int'(busy), int'(!m_idle));
    chk("out_valid", int'(out_valid), int'(m_outv));
    if (m_outv) chk("out_data", int'(out_data), int'(m_outd));
    if (out_valid && !prev_ov) rise_cyc.push_back(cyc);
    prev_ov = out_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [XW-1:0] d);
    int start;
    start    = n_acc;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && n_acc == start; i++) begin
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (n_acc == start) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 60 && n_out < target; i++) begin
      @(posedge clk); #2;
    end
    if (n_out < target) chk("output_timeout", n_out, target);
  endtask

  task automatic run(input logic [XW-1:0] d);
    int t;
    t = n_out;
    send(d);
    wait_out(t + 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
  endtask

  task automatic last_out(input string name, input int exp);
    if (out_q.size() == 0) chk({name, "_missing"}, 0, 1);
    else chk(name, int'(out_q[$]), exp);
  endtask

  // ---------------- directed scenarios ----------------
  logic [YW-1:0] imp_exp [5] = '{10'h020, 10'h3C0, 10'h010, 10'h060, 10'h000};
  logic [YW-1:0] wrp_exp [4] = '{10'h100, 10'h200, 10'h300, 10'h000};
  logic [XW-1:0] thr_in  [10] = '{9'h080, 9'h1F0, 9'h0FF, 9'h100, 9'h033,
                                  9'h000, 9'h1C4, 9'h07A, 9'h155, 9'h0AA};

  initial begin
    int ob, ab, rb, na, nt;
    coeffs = H_IMP;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Impulse response; out_valid is raised by the N-th edge after the
    // accepting edge (edge N+1 counting the accepting edge as the first).
    ob = out_q.size(); ab = acc_cyc.size(); rb = rise_cyc.size();
    run(9'h080);
    for (int i = 0; i < 4; i++) run(9'h000);
    for (int i = 0; i < 5; i++) begin
      if (out_q.size() > ob + i) chk($sformatf("impulse_y%0d", i), int'(out_q[ob+i]), int'(imp_exp[i]));
      else chk($sformatf("impulse_y%0d_missing", i), 0, 1);
      if (rise_cyc.size() > rb + i)
        chk($sformatf("latency_%0d", i), rise_cyc[rb+i] - acc_cyc[ab+i], N);
      else chk($sformatf("latency_%0d_missing", i), 0, 1);
    end

    // Clear in IDLE flushes the history.
    run(9'h080);
    last_out("clear_pre", 'h020);
    pulse_clear();
    run(9'h000);
    last_out("clear_flushed", 'h000);
    // clear together with in_valid: sample wins, history kept.
    run(9'h080);
    clear = 1'b1;
    run(9'h000);
    clear = 1'b0;
    last_out("clear_ignored", 'h3C0);

    // Wrap-around with -1.0 coefficients and samples.
    coeffs = H_NEG1;
    pulse_clear();
    ob = out_q.size();
    for (int i = 0; i < 4; i++) run(9'h100);
    for (int i = 0; i < 4; i++) begin
      if (out_q.size() > ob + i) chk($sformatf("wrap_y%0d", i), int'(out_q[ob+i]), int'(wrp_exp[i]));
      else chk($sformatf("wrap_y%0d_missing", i), 0, 1);
    end

    // Back-pressure in OUT with a pending source sample.
    coeffs = H_IMP;
    pulse_clear();
    out_ready = 1'b0;
    send(9'h080);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #2;
    end
    in_data = 9'h000;
    in_valid = 1'b1;
    na = n_acc;
    repeat (5) begin @(posedge clk); #2; end
    chk("bp_no_accept", n_acc, na);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 'h020);
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    wait_out(n_out + 1);
    for (int i = 0; i < 10 && n_acc == na; i++) begin
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (n_acc > na && out_cyc.size() > 0) chk("bp_accept_gap", acc_cyc[$] - out_cyc[$], 1);
    else chk("bp_accept_missing", 0, 1);
    wait_out(n_out + 1);
    last_out("bp_second", 'h3C0);

    // Reset in the second MAC cycle discards the result and the history.
    send(9'h080);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rstmac_out_valid", int'(out_valid), 0);
    chk("rstmac_busy", int'(busy), 0);
    chk("rstmac_in_ready", int'(in_ready), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run(9'h080);
    last_out("rstmac_after", 'h020);

    // Throughput: in_valid and out_ready held high for 10 samples.
    ab = acc_cyc.size();
    nt = n_out;
    for (int i = 0; i < 10; i++) send(thr_in[i]);
    wait_out(nt + 10);
    for (int i = 1; i < 10; i++) begin
      if (acc_cyc.size() > ab + i) chk($sformatf("period_%0d", i), acc_cyc[ab+i] - acc_cyc[ab+i-1], N + 2);
      else chk($sformatf("period_%0d_missing", i), 0, 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
